y86_decode_rf_fwd: RTL and testbench

- Parametrised successor to the Y86-64 pipeline decode stage.
- Contains a clocked register file with two write ports (W-stage valE/valM), a Y86 source/destination ID generator, a 5-source forwarding network for valA and valB, and the D→E pipeline register with stall/bubble control.
- Sits between the fetch-side D register and the execute stage.
- Replaces the combinational write-in-read-block register file with a deterministic synchronous one.

---
 rtl/y86_pkg.sv | 36 +++
 rtl/y86_decode_rf_fwd_if.sv | 48 ++++
 rtl/y86_regfile.sv | 53 +++++
 rtl/y86_decode_rf_fwd.sv | 146 ++++++++++++++
 tb/tb_y86_decode_rf_fwd.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 decode / register-file /
// forwarding slice.
//   icode_e    - Y86-64 instruction codes (I_HALT..I_POPQ)
//   FWD_*      - source-select codes reported on fwdA_sel / fwdB_sel
//   rnone_of() - "no register" ID for a given register-ID width
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [2:0] FWD_RF    = 3'd0;
  localparam logic [2:0] FWD_VALP  = 3'd1;
  localparam logic [2:0] FWD_EVALE = 3'd2;
  localparam logic [2:0] FWD_MVALM = 3'd3;
  localparam logic [2:0] FWD_MVALE = 3'd4;
  localparam logic [2:0] FWD_WVALM = 3'd5;
  localparam logic [2:0] FWD_WVALE = 3'd6;

  // RNONE is the highest register ID; it is never written or forwarded.
  function automatic int unsigned rnone_of(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/y86_decode_rf_fwd_if.sv
// y86_decode_rf_fwd_if: bundle of all decode-stage signals except clock/reset.
//   D_*            decode-stage instruction fields (from fetch side)
//   e_/M_/m_/W_*   downstream destinations and values used for forwarding
//                  and register write-back
//   E_stall/bubble E register control from the hazard unit
//   dbg_addr/data  debug read port of the register file
//   d_src*, fwd*   combinational IDs / select codes for hazard unit & debug
//   E_*            registered outputs to execute
// master: the pipeline surroundings; slave: the decode block.
interface y86_decode_rf_fwd_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);
  logic [3:0]        D_icode;
  logic [ADDR_W-1:0] D_rA, D_rB;
  logic [DATA_W-1:0] D_valP;
  logic [ADDR_W-1:0] e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic [ADDR_W-1:0] M_dstE, M_dstM;
  logic [DATA_W-1:0] M_valE, m_valM;
  logic [ADDR_W-1:0] W_dstE, W_dstM;
  logic [DATA_W-1:0] W_valE, W_valM;
  logic              E_stall, E_bubble;
  logic [ADDR_W-1:0] dbg_addr;

  logic [ADDR_W-1:0] d_srcA, d_srcB;
  logic [3:0]        E_icode;
  logic [DATA_W-1:0] E_valA, E_valB;
  logic [ADDR_W-1:0] E_srcA, E_srcB, E_dstE, E_dstM;
  logic [2:0]        fwdA_sel, fwdB_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_dstM,
           M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM, E_stall,
           E_bubble, dbg_addr,
    input  d_srcA, d_srcB, E_icode, E_valA, E_valB, E_srcA, E_srcB,
           E_dstE, E_dstM, fwdA_sel, fwdB_sel, dbg_data
  );

  modport slave (
    input  D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_dstM,
           M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM, E_stall,
           E_bubble, dbg_addr,
    output d_srcA, d_srcB, E_icode, E_valA, E_valB, E_srcA, E_srcB,
           E_dstE, E_dstM, fwdA_sel, fwdB_sel, dbg_data
  );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: synchronous Y86 register file.
//   clk, rst_n         clock, synchronous active-low reset
//   raddr_a/b, rdata_a/b  asynchronous read ports (pre-edge contents)
//   dbg_addr, dbg_data    asynchronous debug read port
//   wdst_e/wval_e         write port from W-stage valE
//   wdst_m/wval_m         write port from W-stage valM (wins on same ID)
// Reset clears every register except RSP_ID, which loads RSP_INIT.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              ADDR_W   = 4,
  parameter int              RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(64'h0000_0000_0000_0200)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic [ADDR_W-1:0] wdst_e,
  input  logic [DATA_W-1:0] wval_e,
  input  logic [ADDR_W-1:0] wdst_m,
  input  logic [DATA_W-1:0] wval_m
);
  localparam int              NREG  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RNONE = ADDR_W'(rnone_of(ADDR_W));

  logic [DATA_W-1:0] regs [NREG];

  // Write-back port. The valM write is issued last so it takes the register
  // when both ports target the same ID (popq %rsp).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
    end else begin
      if (wdst_e != RNONE)
        regs[wdst_e] <= wval_e;
      if (wdst_m != RNONE)
        regs[wdst_m] <= wval_m;
    end
  end

  // RNONE always reads as zero regardless of array contents.
  assign rdata_a  = (raddr_a  == RNONE) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == RNONE) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == RNONE) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/y86_decode_rf_fwd.sv
// y86_decode_rf_fwd: Y86-64 decode stage.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         y86_decode_rf_fwd_if.slave: D-stage fields in, forwarding
//               sources in, W write-back in, E register control in;
//               source IDs / forward selects / debug data out (comb) and
//               the E pipeline register out (registered).
// Generates source/destination IDs, selects valA/valB through a priority
// forwarding chain, and holds the D->E pipeline register.
module y86_decode_rf_fwd
  import y86_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              ADDR_W   = 4,
  parameter int              RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(64'h0000_0000_0000_0200)
) (
  input logic               clk,
  input logic               rst_n,
  y86_decode_rf_fwd_if.slave bus
);
  localparam logic [ADDR_W-1:0] RNONE = ADDR_W'(rnone_of(ADDR_W));
  localparam logic [ADDR_W-1:0] RSP   = ADDR_W'(RSP_ID);

  logic [ADDR_W-1:0] src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic [2:0]        sel_a, sel_b;

  logic [3:0]        e_icode_q;
  logic [DATA_W-1:0] e_val_a_q, e_val_b_q;
  logic [ADDR_W-1:0] e_src_a_q, e_src_b_q, e_dst_e_q, e_dst_m_q;

  y86_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RSP_ID  (RSP_ID),
    .RSP_INIT(RSP_INIT)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (src_a),
    .raddr_b (src_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .dbg_addr(bus.dbg_addr),
    .dbg_data(bus.dbg_data),
    .wdst_e  (bus.W_dstE),
    .wval_e  (bus.W_valE),
    .wdst_m  (bus.W_dstM),
    .wval_m  (bus.W_valM)
  );

  // Source/destination register IDs from the instruction code.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      I_RRMOVQ: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
      I_IRMOVQ: dst_e = bus.D_rB;
      I_RMMOVQ: begin src_a = bus.D_rA; src_b = bus.D_rB; end
      I_MRMOVQ: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
      I_OPQ:    begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
      I_CALL:   begin src_b = RSP; dst_e = RSP; end
      I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = bus.D_rA; src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.D_rA; end
      default:  ;
    endcase
  end

  // valA: call/jXX carry valP in valA; otherwise the youngest in-flight
  // producer wins, falling back to the register file.
  always_comb begin
    sel_a = FWD_RF;
    val_a = rf_a;
    if (bus.D_icode == I_CALL || bus.D_icode == I_JXX) begin
      sel_a = FWD_VALP;  val_a = bus.D_valP;
    end else if (src_a != RNONE) begin
      if (src_a == bus.e_dstE) begin
        sel_a = FWD_EVALE; val_a = bus.e_valE;
      end else if (src_a == bus.M_dstM) begin
        sel_a = FWD_MVALM; val_a = bus.m_valM;
      end else if (src_a == bus.M_dstE) begin
        sel_a = FWD_MVALE; val_a = bus.M_valE;
      end else if (src_a == bus.W_dstM) begin
        sel_a = FWD_WVALM; val_a = bus.W_valM;
      end else if (src_a == bus.W_dstE) begin
        sel_a = FWD_WVALE; val_a = bus.W_valE;
      end
    end
  end

  // valB: same chain as valA without the valP step.
  always_comb begin
    sel_b = FWD_RF;
    val_b = rf_b;
    if (src_b != RNONE) begin
      if (src_b == bus.e_dstE) begin
        sel_b = FWD_EVALE; val_b = bus.e_valE;
      end else if (src_b == bus.M_dstM) begin
        sel_b = FWD_MVALM; val_b = bus.m_valM;
      end else if (src_b == bus.M_dstE) begin
        sel_b = FWD_MVALE; val_b = bus.M_valE;
      end else if (src_b == bus.W_dstM) begin
        sel_b = FWD_WVALM; val_b = bus.W_valM;
      end else if (src_b == bus.W_dstE) begin
        sel_b = FWD_WVALE; val_b = bus.W_valE;
      end
    end
  end

  // D->E register: reset and bubble both inject a NOP; stall holds.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.E_bubble) begin
      e_icode_q <= I_NOP;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
      e_src_a_q <= RNONE;
      e_src_b_q <= RNONE;
      e_dst_e_q <= RNONE;
      e_dst_m_q <= RNONE;
    end else if (!bus.E_stall) begin
      e_icode_q <= bus.D_icode;
      e_val_a_q <= val_a;
      e_val_b_q <= val_b;
      e_src_a_q <= src_a;
      e_src_b_q <= src_b;
      e_dst_e_q <= dst_e;
      e_dst_m_q <= dst_m;
    end
  end

  assign bus.d_srcA   = src_a;
  assign bus.d_srcB   = src_b;
  assign bus.fwdA_sel = sel_a;
  assign bus.fwdB_sel = sel_b;
  assign bus.E_icode  = e_icode_q;
  assign bus.E_valA   = e_val_a_q;
  assign bus.E_valB   = e_val_b_q;
  assign bus.E_srcA   = e_src_a_q;
  assign bus.E_srcB   = e_src_b_q;
  assign bus.E_dstE   = e_dst_e_q;
  assign bus.E_dstM   = e_dst_m_q;

endmodule

// File: tb/tb_y86_decode_rf_fwd.sv
// tb_y86_decode_rf_fwd: self-checking bench for y86_decode_rf_fwd.
// Inputs change 2 time units after each rising edge; outputs are compared
// on the falling edge against a behavioural model of the register file,
// ID rules, forwarding priority list and E register.
module tb_y86_decode_rf_fwd;
  localparam logic [3:0] RN = 4'hF;

  logic clk;
  logic rst_n;

  y86_decode_rf_fwd_if #(.DATA_W(64), .ADDR_W(4)) bus ();

  y86_decode_rf_fwd #(
    .DATA_W  (64),
    .ADDR_W  (4),
    .RSP_ID  (4),
    .RSP_INIT(64'h200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic [63:0] valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        stall, bubble;
    logic [3:0]  dbg;
  } vec_t;

  typedef struct {
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [2:0]  selA, selB;
    logic [63:0] valA, valB;
  } dec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [63:0] val;
  } fwd_t;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valA, valB;
    logic [3:0]  srcA, srcB, dstE, dstM;
  } estate_t;

  int      vectors     = 0;
  int      miscompares = 0;
  int      compares    = 0;
  bit      checkEn     = 1'b0;
  logic [63:0] mrf [16];
  estate_t mE;
  dec_t    lastDec;
  vec_t    v;

  function automatic vec_t idleVec();
    vec_t r;
    r.rst_n = 1'b1; r.icode = 4'h1; r.rA = RN; r.rB = RN; r.valP = '0;
    r.e_dstE = RN; r.e_valE = '0; r.M_dstE = RN; r.M_dstM = RN;
    r.M_valE = '0; r.m_valM = '0; r.W_dstE = RN; r.W_dstM = RN;
    r.W_valE = '0; r.W_valM = '0; r.stall = 1'b0; r.bubble = 1'b0;
    r.dbg = '0;
    return r;
  endfunction

  function automatic logic [63:0] rfRead(logic [3:0] id);
    return (id == RN) ? 64'h0 : mrf[id];
  endfunction

  // Walk the producers youngest-first; the first live match supplies the value.
  function automatic fwd_t pick(logic [3:0] src);
    fwd_t        f;
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    bit          found;
    ids  = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    f.sel = 3'd0;
    f.val = rfRead(src);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && src != RN && ids[k] == src) begin
        f.sel = 3'(k + 2);
        f.val = vals[k];
        found = 1'b1;
      end
    end
    return f;
  endfunction

  function automatic dec_t modelDecode();
    dec_t       d;
    fwd_t       fa, fb;
    logic [3:0] ic;
    ic = bus.D_icode;
    d.srcA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.D_rA :
             (ic inside {4'h9, 4'hB}) ? 4'd4 : RN;
    d.srcB = (ic inside {4'h4, 4'h5, 4'h6}) ? bus.D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : RN;
    d.dstE = (ic inside {4'h2, 4'h3, 4'h6}) ? bus.D_rB :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : RN;
    d.dstM = (ic inside {4'h5, 4'hB}) ? bus.D_rA : RN;
    fa = pick(d.srcA);
    fb = pick(d.srcB);
    if (ic inside {4'h7, 4'h8}) begin
      fa.sel = 3'd1;
      fa.val = bus.D_valP;
    end
    d.selA = fa.sel; d.valA = fa.val;
    d.selB = fb.sel; d.valB = fb.val;
    return d;
  endfunction

  function automatic estate_t bubbleState();
    estate_t e;
    e.icode = 4'h1; e.valA = '0; e.valB = '0;
    e.srcA = RN; e.srcB = RN; e.dstE = RN; e.dstM = RN;
    return e;
  endfunction

  function automatic estate_t loadState(dec_t d, logic [3:0] ic);
    estate_t e;
    e.icode = ic; e.valA = d.valA; e.valB = d.valB;
    e.srcA = d.srcA; e.srcB = d.srcB; e.dstE = d.dstE; e.dstM = d.dstM;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    rst_n        = s.rst_n;
    bus.D_icode  = s.icode;  bus.D_rA = s.rA;  bus.D_rB = s.rB;
    bus.D_valP   = s.valP;
    bus.e_dstE   = s.e_dstE; bus.e_valE = s.e_valE;
    bus.M_dstE   = s.M_dstE; bus.M_dstM = s.M_dstM;
    bus.M_valE   = s.M_valE; bus.m_valM = s.m_valM;
    bus.W_dstE   = s.W_dstE; bus.W_dstM = s.W_dstM;
    bus.W_valE   = s.W_valE; bus.W_valM = s.W_valM;
    bus.E_stall  = s.stall;  bus.E_bubble = s.bubble;
    bus.dbg_addr = s.dbg;
    vectors++;
  endtask

  task automatic checkOutput();
    cmp("d_srcA",   64'(bus.d_srcA),   64'(lastDec.srcA));
    cmp("d_srcB",   64'(bus.d_srcB),   64'(lastDec.srcB));
    cmp("fwdA_sel", 64'(bus.fwdA_sel), 64'(lastDec.selA));
    cmp("fwdB_sel", 64'(bus.fwdB_sel), 64'(lastDec.selB));
    cmp("dbg_data", bus.dbg_data,      rfRead(bus.dbg_addr));
    cmp("E_icode",  64'(bus.E_icode),  64'(mE.icode));
    cmp("E_valA",   bus.E_valA,        mE.valA);
    cmp("E_valB",   bus.E_valB,        mE.valB);
    cmp("E_srcA",   64'(bus.E_srcA),   64'(mE.srcA));
    cmp("E_srcB",   64'(bus.E_srcB),   64'(mE.srcB));
    cmp("E_dstE",   64'(bus.E_dstE),   64'(mE.dstE));
    cmp("E_dstM",   64'(bus.E_dstM),   64'(mE.dstM));
  endtask

  // Compare process: decode the current inputs with the model, then check.
  always @(negedge clk) begin
    lastDec = modelDecode();
    if (checkEn)
      checkOutput();
  end

  // Model state update at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        mrf[i] <= (i == 4) ? 64'h200 : 64'h0;
      mE <= bubbleState();
    end else begin
      if (bus.E_bubble)
        mE <= bubbleState();
      else if (!bus.E_stall)
        mE <= loadState(lastDec, bus.D_icode);
      if (bus.W_dstE != RN) mrf[bus.W_dstE] <= bus.W_valE;
      if (bus.W_dstM != RN) mrf[bus.W_dstM] <= bus.W_valM;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset while stalled: reset must still load the bubble state.
    v = idleVec(); v.rst_n = 1'b0; v.stall = 1'b1;
    v.icode = 4'h6; v.rA = 4'd1; v.rB = 4'd2;
    applyStimulus(v);
    tick();
    checkEn = 1'b1;
    cmp("lit_rst_E_icode", 64'(bus.E_icode), 64'h1);
    cmp("lit_rst_E_srcA",  64'(bus.E_srcA),  64'hF);
    cmp("lit_rst_E_srcB",  64'(bus.E_srcB),  64'hF);
    cmp("lit_rst_E_dstE",  64'(bus.E_dstE),  64'hF);
    cmp("lit_rst_E_dstM",  64'(bus.E_dstM),  64'hF);
    cmp("lit_rst_E_valA",  bus.E_valA,       64'h0);

    for (int a = 0; a < 16; a++) begin
      v = idleVec(); v.dbg = 4'(a);
      applyStimulus(v);
      @(negedge clk);
      cmp("lit_rst_dbg", bus.dbg_data, (a == 4) ? 64'h200 : 64'h0);
      tick();
    end

    // irmovq write-back of r3 while an OPq reads r3 as rB.
    v = idleVec(); v.icode = 4'h6; v.rA = 4'd1; v.rB = 4'd3;
    v.W_dstE = 4'd3; v.W_valE = 64'h55;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_wfwd_selB", 64'(bus.fwdB_sel), 64'd6);
    tick();
    cmp("lit_wfwd_E_valB", bus.E_valB, 64'h55);
    v = idleVec(); v.dbg = 4'd3;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_wfwd_dbg3", bus.dbg_data, 64'h55);
    tick();

    // Forwarding priority on r2.
    v = idleVec(); v.icode = 4'h2; v.rA = 4'd2; v.rB = 4'd5;
    v.e_dstE = 4'd2; v.e_valE = 64'hA;
    v.M_dstM = 4'd2; v.m_valM = 64'hB;
    v.W_dstE = 4'd2; v.W_valE = 64'hC;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_prio_selA_e", 64'(bus.fwdA_sel), 64'd2);
    tick();
    cmp("lit_prio_valA_e", bus.E_valA, 64'hA);
    v.e_dstE = RN;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_prio_selA_m", 64'(bus.fwdA_sel), 64'd3);
    tick();
    cmp("lit_prio_valA_m", bus.E_valA, 64'hB);

    // popq %rsp: both write ports hit r4, valM wins.
    v = idleVec(); v.W_dstE = 4'd4; v.W_valE = 64'h208;
    v.W_dstM = 4'd4; v.W_valM = 64'h77;
    applyStimulus(v);
    tick();
    v = idleVec(); v.dbg = 4'd4;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_popq_dbg4", bus.dbg_data, 64'h77);
    tick();

    // call: valA carries valP; srcB=%rsp forwarded from M_valE.
    v = idleVec(); v.icode = 4'h8; v.valP = 64'h1234; v.rA = 4'd2; v.rB = 4'd7;
    v.e_dstE = 4'd2; v.e_valE = 64'hEE; v.M_dstE = 4'd4; v.M_valE = 64'h99;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_call_selA", 64'(bus.fwdA_sel), 64'd1);
    cmp("lit_call_selB", 64'(bus.fwdB_sel), 64'd4);
    tick();
    cmp("lit_call_E_valA", bus.E_valA,       64'h1234);
    cmp("lit_call_E_valB", bus.E_valB,       64'h99);
    cmp("lit_call_E_srcB", 64'(bus.E_srcB),  64'd4);
    cmp("lit_call_E_dstE", 64'(bus.E_dstE),  64'd4);

    // Load an OPq, then stall for two cycles with changing D inputs.
    v = idleVec(); v.icode = 4'h6; v.rA = 4'd3; v.rB = 4'd2;
    applyStimulus(v);
    tick();
    v.stall = 1'b1; v.icode = 4'h2; v.rA = 4'd5;
    applyStimulus(v);
    tick();
    cmp("lit_stall1_icode", 64'(bus.E_icode), 64'h6);
    cmp("lit_stall1_srcA",  64'(bus.E_srcA),  64'd3);
    cmp("lit_stall1_valA",  bus.E_valA,       64'h55);
    v.icode = 4'hB; v.rA = 4'd6;
    applyStimulus(v);
    tick();
    cmp("lit_stall2_icode", 64'(bus.E_icode), 64'h6);
    cmp("lit_stall2_valB",  bus.E_valB,       64'hC);
    cmp("lit_stall2_dstE",  64'(bus.E_dstE),  64'd2);
    v.bubble = 1'b1;
    applyStimulus(v);
    tick();
    cmp("lit_bub_icode", 64'(bus.E_icode), 64'h1);
    cmp("lit_bub_srcA",  64'(bus.E_srcA),  64'hF);
    cmp("lit_bub_valA",  bus.E_valA,       64'h0);

    // Mid-operation reset overrides a pending write.
    v = idleVec(); v.rst_n = 1'b0; v.icode = 4'h6; v.rA = 4'd1; v.rB = 4'd2;
    v.W_dstE = 4'd5; v.W_valE = 64'h123;
    applyStimulus(v);
    tick();
    cmp("lit_mrst_icode", 64'(bus.E_icode), 64'h1);
    v = idleVec(); v.dbg = 4'd2;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_mrst_dbg2", bus.dbg_data, 64'h0);
    tick();
    v = idleVec(); v.dbg = 4'd5;
    applyStimulus(v);
    @(negedge clk);
    cmp("lit_mrst_dbg5", bus.dbg_data, 64'h0);
    tick();

    // Mixed traffic, checked by the model every cycle.
    for (int n = 0; n < 60; n++) begin
      v = idleVec();
      v.rst_n  = ($urandom_range(0, 30) != 0);
      v.icode  = 4'($urandom_range(0, 11));
      v.rA     = ($urandom_range(0, 5) == 0) ? RN : 4'($urandom_range(0, 5));
      v.rB     = ($urandom_range(0, 5) == 0) ? RN : 4'($urandom_range(0, 5));
      v.valP   = {$urandom, $urandom};
      v.e_dstE = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 5));
      v.M_dstE = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 5));
      v.M_dstM = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 5));
      v.W_dstE = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 5));
      v.W_dstM = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 5));
      v.e_valE = {$urandom, $urandom};
      v.M_valE = {$urandom, $urandom};
      v.m_valM = {$urandom, $urandom};
      v.W_valE = {$urandom, $urandom};
      v.W_valM = {$urandom, $urandom};
      v.stall  = ($urandom_range(0, 5) == 0);
      v.bubble = ($urandom_range(0, 7) == 0);
      v.dbg    = 4'($urandom_range(0, 15));
      applyStimulus(v);
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
